// File: rtl/bpsk_tx_scheduler_if.sv
// bpsk_tx_scheduler_if: encoder handshakes and modulator-side outputs of the BPSK transmit scheduler
interface bpsk_tx_scheduler_if #(
    parameter int HAM_N = 7,
    parameter int BCH_N = 15
);
    logic             enable;
    logic [HAM_N-1:0] ham_data;
    logic             ham_valid;
    logic             ham_ready;
    logic [BCH_N-1:0] bch_data;
    logic             bch_valid;
    logic             bch_ready;
    logic             flag;
    logic             sym_valid;
    logic             sym_strobe;
    logic             frame_start;
    logic             frame_end;
    logic             code_sel;
    logic             busy;

    modport master (
        output enable, ham_data, ham_valid, bch_data, bch_valid,
        input  ham_ready, bch_ready, flag, sym_valid, sym_strobe,
               frame_start, frame_end, code_sel, busy
    );

    modport slave (
        input  enable, ham_data, ham_valid, bch_data, bch_valid,
        output ham_ready, bch_ready, flag, sym_valid, sym_strobe,
               frame_start, frame_end, code_sel, busy
    );
endinterface

// File: rtl/bpsk_tx_scheduler.sv
// bpsk_tx_scheduler: round-robin Hamming/BCH arbiter and MSB-first bit serializer for the BPSK Flag; BPSK_SCHED_PREAMBLE_EN adds an 8-symbol 1010 preamble
module bpsk_tx_scheduler #(
    parameter int HAM_N = 7,
    parameter int BCH_N = 15,
    parameter int SPB   = 4
) (
    input logic                i_clk,
    input logic                i_rst,
    bpsk_tx_scheduler_if.slave bus
);
    localparam int         CW       = $clog2(BCH_N + 1);
    localparam logic [7:0] SYM_LAST = 8'(SPB - 1);

`ifdef BPSK_SCHED_PREAMBLE_EN
    typedef enum logic [1:0] {IDLE, PRE, SEND} state_t;
`else
    typedef enum logic {IDLE, SEND} state_t;
`endif

    state_t           r_state;
    logic [BCH_N-1:0] r_sr;
    logic [CW-1:0]    r_bits;
    logic [7:0]       r_sym;
    logic             r_last;
    logic             r_flag;
    logic             r_sym_valid;
    logic             r_sym_strobe;
    logic             r_frame_start;
    logic             r_frame_end;
    logic             r_code_sel;
    logic             r_busy;
`ifdef BPSK_SCHED_PREAMBLE_EN
    logic [2:0]       r_pre;
    logic [2:0]       w_pre_n;
`endif

    logic             w_idle_en;
    logic             w_ham_rdy;
    logic             w_bch_rdy;
    logic             w_ham_acc;
    logic             w_bch_acc;
    logic             w_acc;
    logic             w_sym_end;
    state_t           w_state_n;
    logic [BCH_N-1:0] w_sr_n;
    logic [CW-1:0]    w_bits_n;
    logic [7:0]       w_sym_n;

    // r_last=1 means BCH was served last, so Hamming wins a tie
    assign w_idle_en = (r_state == IDLE) && bus.enable && !i_rst;
    assign w_ham_rdy = w_idle_en && bus.ham_valid && (!bus.bch_valid || r_last);
    assign w_bch_rdy = w_idle_en && bus.bch_valid && (!bus.ham_valid || !r_last);
    assign w_ham_acc = w_ham_rdy && bus.ham_valid;
    assign w_bch_acc = w_bch_rdy && bus.bch_valid;
    assign w_acc     = w_ham_acc || w_bch_acc;
    assign w_sym_end = (r_sym == SYM_LAST);

    assign bus.ham_ready   = w_ham_rdy;
    assign bus.bch_ready   = w_bch_rdy;
    assign bus.flag        = r_flag;
    assign bus.sym_valid   = r_sym_valid;
    assign bus.sym_strobe  = r_sym_strobe;
    assign bus.frame_start = r_frame_start;
    assign bus.frame_end   = r_frame_end;
    assign bus.code_sel    = r_code_sel;
    assign bus.busy        = r_busy;

    // next state, shift register and counters; outputs are registered from these lookahead values
    always_comb begin
        w_state_n = r_state;
        w_sr_n    = r_sr;
        w_bits_n  = r_bits;
        w_sym_n   = r_sym;
`ifdef BPSK_SCHED_PREAMBLE_EN
        w_pre_n   = r_pre;
`endif
        case (r_state)
            IDLE: begin
                if (w_acc) begin
                    w_sr_n   = w_ham_acc ? {bus.ham_data, {(BCH_N-HAM_N){1'b0}}} : bus.bch_data;
                    w_bits_n = w_ham_acc ? CW'(HAM_N) : CW'(BCH_N);
                    w_sym_n  = 8'd0;
`ifdef BPSK_SCHED_PREAMBLE_EN
                    w_pre_n   = 3'd0;
                    w_state_n = PRE;
`else
                    w_state_n = SEND;
`endif
                end
            end
`ifdef BPSK_SCHED_PREAMBLE_EN
            PRE: begin
                w_sym_n = w_sym_end ? 8'd0 : r_sym + 8'd1;
                if (w_sym_end) begin
                    w_pre_n   = r_pre + 3'd1;
                    w_state_n = (r_pre == 3'd7) ? SEND : PRE;
                end
            end
`endif
            SEND: begin
                w_sym_n = w_sym_end ? 8'd0 : r_sym + 8'd1;
                if (w_sym_end) begin
                    w_sr_n    = r_sr << 1;
                    w_bits_n  = r_bits - CW'(1);
                    w_state_n = (r_bits == CW'(1)) ? IDLE : SEND;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    // state, datapath and registered outputs; reset aborts any frame without a FrameEnd
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_sr          <= '0;
            r_bits        <= '0;
            r_sym         <= '0;
            r_last        <= 1'b1;
            r_flag        <= 1'b1;
            r_sym_valid   <= 1'b0;
            r_sym_strobe  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
            r_code_sel    <= 1'b0;
            r_busy        <= 1'b0;
`ifdef BPSK_SCHED_PREAMBLE_EN
            r_pre         <= '0;
`endif
        end else begin
            r_state       <= w_state_n;
            r_sr          <= w_sr_n;
            r_bits        <= w_bits_n;
            r_sym         <= w_sym_n;
            r_last        <= w_acc ? w_bch_acc : r_last;
            r_code_sel    <= w_acc ? w_bch_acc : r_code_sel;
`ifdef BPSK_SCHED_PREAMBLE_EN
            r_pre         <= w_pre_n;
            r_flag        <= (w_state_n == SEND) ? w_sr_n[BCH_N-1] : (w_state_n == PRE) ? ~w_pre_n[0] : 1'b1;
`else
            r_flag        <= (w_state_n == SEND) ? w_sr_n[BCH_N-1] : 1'b1;
`endif
            r_sym_valid   <= (w_state_n != IDLE);
            r_busy        <= (w_state_n != IDLE);
            r_sym_strobe  <= (w_state_n != IDLE) && (w_sym_n == 8'd0);
            r_frame_start <= w_acc;
            r_frame_end   <= (w_state_n == SEND) && (w_sym_n == SYM_LAST) && (w_bits_n == CW'(1));
        end
    end
endmodule

// File: tb/tb_bpsk_tx_scheduler.sv
// tb_bpsk_tx_scheduler: vector table, directed sequences and random traffic against a frame-timeline reference model
module tb_bpsk_tx_scheduler;
    localparam int SPB = 4;
`ifdef BPSK_SCHED_PREAMBLE_EN
    localparam int PRE_SYMS = 8;
`else
    localparam int PRE_SYMS = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic rst_b;
    always #5 clk = ~clk;

    bpsk_tx_scheduler_if #(.HAM_N(7), .BCH_N(15)) bus ();
    bpsk_tx_scheduler_if #(.HAM_N(7), .BCH_N(15)) bus_b ();

    bpsk_tx_scheduler #(.HAM_N(7), .BCH_N(15), .SPB(SPB)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
    bpsk_tx_scheduler #(.HAM_N(7), .BCH_N(15), .SPB(1)) dut_b (.i_clk(clk), .i_rst(rst_b), .bus(bus_b));

    int n_err = 0;
    int n_chk = 0;

    // reference model: the expected Flag waveform of the current frame and our position in it
    int m_pos = -1;
    int m_len = 0;
    bit m_last = 1'b1;
    bit m_code = 1'b0;
    bit m_wave[$];

    typedef struct {
        bit r, e, hv, bv, eh, eb;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%b exp=%b", name, $time, act, exp);
        end
    endtask

    task automatic start_frame(input bit b, input logic [14:0] w);
        int n;
        m_wave.delete();
        for (int k = 0; k < PRE_SYMS; k++)
            for (int s = 0; s < SPB; s++) m_wave.push_back(bit'(k % 2 == 0));
        n = b ? 15 : 7;
        for (int i = 0; i < n; i++)
            for (int s = 0; s < SPB; s++) m_wave.push_back(w[14-i]);
        m_len  = m_wave.size();
        m_pos  = 0;
        m_last = b;
        m_code = b;
    endtask

    task automatic check_outputs();
        bit f;
        f = (m_pos >= 0);
        chk("flag", bus.flag, f ? m_wave[m_pos] : 1'b1);
        chk("sym_valid", bus.sym_valid, f);
        chk("busy", bus.busy, f);
        chk("sym_strobe", bus.sym_strobe, f && (m_pos % SPB == 0));
        chk("frame_start", bus.frame_start, f && (m_pos == 0));
        chk("frame_end", bus.frame_end, f && (m_pos == m_len - 1));
        chk("code_sel", bus.code_sel, m_code);
    endtask

    task automatic cycle(input bit r, input bit e, input bit hv, input bit bv,
                         input logic [6:0] hd, input logic [14:0] bd);
        bit gh, gb;
        check_outputs();
        rst           = r;
        bus.enable    = e;
        bus.ham_valid = hv;
        bus.bch_valid = bv;
        bus.ham_data  = hd;
        bus.bch_data  = bd;
        #1;
        gh = (m_pos < 0) && !r && e && hv && (!bv || m_last);
        gb = (m_pos < 0) && !r && e && bv && !gh;
        chk("ham_ready", bus.ham_ready, gh);
        chk("bch_ready", bus.bch_ready, gb);
        @(posedge clk);
        if (r) begin
            m_pos  = -1;
            m_last = 1'b1;
            m_code = 1'b0;
        end else if (gh || gb) begin
            start_frame(gb, gb ? bd : {hd, 8'b0});
        end else if (m_pos >= 0) begin
            m_pos++;
            if (m_pos == m_len) m_pos = -1;
        end
        @(negedge clk);
    endtask

    initial begin
        tbl[0] = '{r:0, e:1, hv:1, bv:0, eh:1, eb:0};
        tbl[1] = '{r:0, e:1, hv:0, bv:1, eh:0, eb:1};
        tbl[2] = '{r:0, e:1, hv:1, bv:1, eh:1, eb:0};
        tbl[3] = '{r:0, e:0, hv:1, bv:1, eh:0, eb:0};
        tbl[4] = '{r:1, e:1, hv:1, bv:1, eh:0, eb:0};
        tbl[5] = '{r:0, e:1, hv:0, bv:0, eh:0, eb:0};

        rst = 1'b1;
        rst_b = 1'b1;
        bus.enable = 1'b0; bus.ham_valid = 1'b0; bus.bch_valid = 1'b0;
        bus.ham_data = '0; bus.bch_data = '0;
        bus_b.enable = 1'b0; bus_b.ham_valid = 1'b0; bus_b.bch_valid = 1'b0;
        bus_b.ham_data = '0; bus_b.bch_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        rst_b = 1'b0;

        // arbitration vectors in IDLE; valids drop before the edge so nothing is accepted
        for (int i = 0; i < 6; i++) begin
            check_outputs();
            rst = tbl[i].r;
            bus.enable = tbl[i].e;
            bus.ham_valid = tbl[i].hv;
            bus.bch_valid = tbl[i].bv;
            #1;
            chk("tbl_ham_ready", bus.ham_ready, tbl[i].eh);
            chk("tbl_bch_ready", bus.bch_ready, tbl[i].eb);
            rst = 1'b0;
            bus.ham_valid = 1'b0;
            bus.bch_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end

        // single Hamming frame 1011001
        cycle(0, 1, 1, 0, 7'b1011001, 15'h0);
        repeat (40 + 4 * PRE_SYMS) cycle(0, 1, 0, 0, 7'b0, 15'h0);

        // both valid continuously: grants alternate with a one-clock gap
        repeat (200 + 8 * PRE_SYMS * SPB) cycle(0, 1, 1, 1, 7'b1011001, 15'h4D2B);
        repeat (80 + 4 * PRE_SYMS) cycle(0, 1, 0, 0, 7'b0, 15'h0);

        // Enable dropped on the third codeword bit of a Hamming frame
        cycle(0, 1, 1, 0, 7'b0110101, 15'h0);
        repeat (2 * SPB + PRE_SYMS * SPB) cycle(0, 1, 0, 0, 7'b0, 15'h0);
        repeat (60) cycle(0, 0, 1, 0, 7'b0110101, 15'h0);

        // reset on the fifth bit of a BCH frame, then a tie goes to Hamming
        cycle(0, 1, 0, 1, 7'b0, 15'h4D2B);
        repeat (4 * SPB + PRE_SYMS * SPB) cycle(0, 1, 0, 0, 7'b0, 15'h0);
        cycle(1, 1, 1, 1, 7'b1100110, 15'h2AAA);
        repeat (120 + 4 * PRE_SYMS) cycle(0, 1, 1, 1, 7'b1100110, 15'h2AAA);
        repeat (100 + 4 * PRE_SYMS) cycle(0, 0, 0, 0, 7'b0, 15'h0);

        // SPB=1 instance: all-zero Hamming codeword
        bus_b.enable = 1'b1;
        bus_b.ham_valid = 1'b1;
        #1;
        chk("b_ham_ready", bus_b.ham_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus_b.ham_valid = 1'b0;
        chk("b_frame_start", bus_b.frame_start, 1'b1);
        for (int i = 0; i < PRE_SYMS; i++) begin
            chk("b_pre_flag", bus_b.flag, bit'(i % 2 == 0));
            @(negedge clk);
        end
        for (int i = 0; i < 7; i++) begin
            chk("b_flag", bus_b.flag, 1'b0);
            chk("b_sym_strobe", bus_b.sym_strobe, 1'b1);
            chk("b_frame_end", bus_b.frame_end, i == 6);
            @(negedge clk);
        end
        chk("b_idle_flag", bus_b.flag, 1'b1);
        chk("b_idle_busy", bus_b.busy, 1'b0);

        // random traffic with occasional reset and Enable gaps
        for (int i = 0; i < 4000; i++)
            cycle($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0,
                  1'($urandom), 1'($urandom), 7'($urandom), 15'($urandom));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/bpsk_tx_scheduler.md
# bpsk_tx_scheduler

Transmit-side scheduler feeding the BPSK modulator. Arbitrates between the Hamming(7,4) and BCH(15,x) encoder outputs with a valid/ready handshake and round-robin fairness, then serializes the granted codeword MSB-first. Each bit drives the modulator's Flag input for SPB clocks: 1 passes the carrier, 0 inverts it. Sits between the two encoders and the modulator; the carrier word on the modulator's DataIn is supplied elsewhere.

## Interface
- HAM_N, 7: Hamming codeword width.
- BCH_N, 15: BCH codeword width.
- SPB, 4: clocks per symbol (bit); legal range 1..255.
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous reset, active-high.
- Enable  in  1  permits acceptance of new frames; does not affect a frame in progress.
- HamData  in  HAM_N  Hamming codeword.
- HamValid  in  1  HamData valid.
- HamReady  out  1  scheduler accepts HamData this cycle.
- BchData  in  BCH_N  BCH codeword.
- BchValid  in  1  BchData valid.
- BchReady  out  1  scheduler accepts BchData this cycle.
- Flag  out  1  modulator Flag: current bit; 1 when idle.
- SymValid  out  1  Flag carries a frame or preamble symbol.
- SymStrobe  out  1  first clock of each symbol.
- FrameStart  out  1  one-cycle pulse on the first clock of the first symbol of a frame, preamble included.
- FrameEnd  out  1  one-cycle pulse on the last clock of the last codeword symbol.
- CodeSel  out  1  source of the current or last frame: 0 Hamming, 1 BCH.
- Busy  out  1  high in any state except IDLE.

## Operation
- FSM states: IDLE, PRE (only with the macro), SEND.
- Grant rule in IDLE with Enable=1:
  - A single valid requester wins.
  - If both are valid, the requester not served last wins.
  - Register `last` resets to BCH, so Hamming wins the first tie.
- HamReady and BchReady are combinational from the state, Enable, both Valids and `last`. At most one is high. Both are 0 outside IDLE, when Enable=0, or when RST=1.
- Accept cycle (Valid & Ready):
  - Load the codeword into a BCH_N-bit shift register, left-aligned; Hamming fills the upper 7 bits.
  - Load bit count = HAM_N or BCH_N.
  - Update CodeSel and `last`.
  - Next state is PRE if the macro is defined, else SEND.
- SEND:
  - Flag = shift-register MSB.
  - A symbol counter counts 0..SPB-1. At SPB-1 the register shifts left by one and the bit count decrements.
  - After the final bit's SPB-1 clock, assert FrameEnd and go to IDLE.
- IDLE:
  - Flag=1, SymValid=0.
  - Minimum one IDLE cycle between frames, so back-to-back frames have a gap of exactly 1 clock.
- Enable falling mid-frame: the frame completes normally and no new accept occurs.
- RST mid-frame: the frame is aborted at that edge. No FrameEnd is issued and all outputs return to reset values.
- Reset values: Flag=1; SymValid=0, SymStrobe=0, FrameStart=0, FrameEnd=0, CodeSel=0, Busy=0; state IDLE; `last`=BCH; counters=0.

## Timing
- Accept at clock t. The first symbol occupies clocks t+1 .. t+SPB, with SymStrobe and FrameStart at t+1.
- Frame length: N·SPB clocks without preamble, (8+N)·SPB clocks with it. N = 7 or 15.
- FrameEnd is on the last SEND clock. IDLE follows, and the next accept can occur on that IDLE clock.
- SPB=1: SymStrobe is high every clock of the frame.
- Outputs are registered, except HamReady and BchReady.

## Configuration
- BPSK_SCHED_PREAMBLE_EN defined:
  - PRE sends 8 symbols of 1,0,1,0,1,0,1,0 on Flag, SymValid=1, before the codeword.
  - FrameStart is on the first preamble symbol.
  - CodeSel and `last` update at accept as usual.
- Undefined: the PRE state and its counter are absent, and SEND follows accept directly.

## Test plan
- Reset, SPB=4, no macro; HamData=7'b1011001 valid at accept clock t.
  - HamReady=1 at t.
  - Flag = 1,0,1,1,0,0,1, each held 4 clocks over t+1..t+28.
  - FrameEnd at t+28; Busy low at t+29.
- HamValid and BchValid held high continuously, BchData=15'h4D2B. Grants alternate Ham, BCH, Ham, BCH, with a 1-clock IDLE gap between frames. BCH frame length is 60 clocks.
- Macro defined, SPB=2, BchData=15'h7FFF.
  - Flag = 10101010 preamble (16 clocks), then 15 ones (30 clocks).
  - FrameStart at the first preamble clock; FrameEnd 46 clocks later inclusive.
- Enable dropped on the 3rd bit of a Hamming frame. The frame completes with FrameEnd. No Ready is asserted afterwards while HamValid=1 and Enable=0.
- RST pulsed on the 5th bit of a BCH frame.
  - The next clock shows Flag=1, SymValid=0, Busy=0, and no FrameEnd.
  - With both Valids high afterwards, Hamming wins the first grant.
- SPB=1, Hamming 7'b0000000: Flag=0 for exactly 7 clocks, with SymStrobe high on all 7.
